subckt_pattern_driver: RTL and testbench
========================================

# subckt_pattern_driver

Built-in stimulus/response engine for the `test_I*` trojan-detection subcircuits. It sits on the other side of a subcircuit's input pins and output pin. It drives pseudo-random patterns from a Galois LFSR onto the subcircuit inputs and compacts the single-bit response into a MISR, aligned to the subcircuit's flop depth. At the end of a run it compares the MISR against a golden signature. It is one block per benchmark netlist, instanced in the detection harness.

## Interface
- `N_IN`, 3: stimulus width, one bit per subcircuit data input.
- `LFSR_W`, 16: LFSR width.
- `LFSR_POLY`, 16'hB400: Galois feedback mask.
- `SEED`, 16'hACE1: LFSR reset/start value; 0 is replaced by 1.
- `MISR_W`, 16: signature width.
- `MISR_POLY`, 16'h1021: MISR feedback mask.
- `N_PATTERNS`, 256: patterns per run, ≥1.
- `LATENCY`, 6: subcircuit input-to-output flop depth, ≥1.
- `I1294_clk` in 1: the single clock; every register is rising-edge.
- `I1301_rst` in 1: reset; **synchronous, active-low**.
- `start` in 1: one-cycle request to begin a run; sampled only in IDLE or DONE.
- `golden` in MISR_W: expected signature; sampled on the cycle FLUSH exits.
- `resp_in` in 1: subcircuit output.
- `pattern_out` out N_IN: stimulus to the subcircuit inputs; registered.
- `busy` out 1: high in DRIVE and FLUSH.
- `done` out 1: high in DONE; held until the next start or reset.
- `pass` out 1: `signature == golden`, latched at DONE entry.
- `signature` out MISR_W: current MISR value.

## Operation
- FSM: IDLE → DRIVE → FLUSH → DONE → (on start) DRIVE.
- **IDLE**
  - `start` moves the FSM to DRIVE.
  - On entry from start: LFSR loads SEED, MISR clears to 0, pattern counter clears.
- **DRIVE**
  - `pattern_out` = `lfsr[N_IN-1:0]` each cycle.
  - LFSR step: `lsb ? (lfsr>>1)^LFSR_POLY : lfsr>>1`.
  - Counter increments each cycle. After N_PATTERNS cycles the FSM moves to FLUSH.
- **FLUSH**
  - `pattern_out` = 0; LFSR frozen.
  - Lasts exactly LATENCY cycles, then the FSM moves to DONE.
- **DONE**
  - `pass` latched. `pattern_out` = 0.
  - `start` restarts: reseed the LFSR, clear the MISR, go to DRIVE.
- **Response alignment**
  - A LATENCY-deep valid shift line is loaded with 1 in each DRIVE cycle and 0 otherwise.
  - The MISR updates only when the line's output is 1: `next = (misr<<1) ^ (misr[MSB] ? MISR_POLY : 0) ^ resp_in`.
- Exactly N_PATTERNS response samples are compacted per run. The MISR is never updated in IDLE or DONE.
- `start` while busy is ignored: no restart, no queuing.
- Pattern counter width is `$clog2(N_PATTERNS+1)`; it never wraps within a run.

## Timing
- Reset (`I1301_rst`=0 at a clock edge): state IDLE; `pattern_out`=0, `busy`=0, `done`=0, `pass`=0, `signature`=0; LFSR=SEED; valid line cleared.
- Reset mid-run aborts immediately with the same values. No partial signature survives.
- `start` sampled high at edge t:
  - `busy`=1 and first pattern (`SEED[N_IN-1:0]`) from t+1.
  - Pattern k (k=0..N_PATTERNS-1) is driven in cycle t+1+k.
  - Its response is compacted at edge t+1+k+LATENCY.
- DONE is entered, with `done`=1 and `busy`=0, at t+1+N_PATTERNS+LATENCY.
- `pass` is valid in the same cycle `done` rises.
- `start` in DONE at edge u: `done`=0 and `busy`=1 from u+1; timing is identical to a start from IDLE.

## Structure
- Shared package `subckt_bist_pkg` holds:
  - the state enum (IDLE/DRIVE/FLUSH/DONE);
  - default LFSR/MISR polynomials and seed;
  - `lfsr_step()` and `misr_step()` functions.
- One sub-module, `bist_misr`: a MISR register with enable and clear. The LFSR, counter, valid line and FSM stay in the top level.

## Test plan
- **Reset values:** hold `I1301_rst`=0 for 3 cycles, then release → all outputs 0, state IDLE; no change without `start`.
- **First patterns:** defaults, `start` pulse → `pattern_out`=3'b001 in cycle 1 and 3'b000 in cycle 2 (LFSR 16'hACE1 → 16'hE270). `busy` is high for 256+6 cycles, then `done`=1.
- **Alignment:** N_PATTERNS=2, LATENCY=6, `resp_in` held 1 → `signature` goes 0x0000 → 0x0001 → 0x0003. Updates occur at t+7 and t+8 only. With `golden`=16'h0003, `pass`=1.
- **Mismatch:** same run with `golden`=16'h0002 → `done`=1, `pass`=0.
- **Start while busy / restart:**
  - `start` pulsed mid-DRIVE → no effect on the counter, LFSR or done time.
  - `start` in DONE → signature cleared and a full identical run repeats with the same signature.
- **Reset mid-run:** assert reset at DRIVE cycle 50 → next cycle IDLE, `signature`=0, `busy`=0. A new start reproduces the uninterrupted signature.

Source files
------------

// File: rtl/subckt_bist_pkg.sv
// Shared definitions for the subcircuit pattern driver.
//   - bist_state_e : run-control FSM states
//   - Def*         : default LFSR/MISR polynomials and LFSR seed
//   - lfsr_step()  : one Galois LFSR shift (right-shifting, feedback on lsb)
//   - misr_step()  : one MISR compaction step of a single response bit
// Both step functions work on a 64-bit container so that callers of any width up to 64 can
// share them; callers size-cast arguments in and results out.
package subckt_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StFlush,
    StDone
  } bist_state_e;

  localparam logic [15:0] DefLfsrPoly = 16'hB400;
  localparam logic [15:0] DefLfsrSeed = 16'hACE1;
  localparam logic [15:0] DefMisrPoly = 16'h1021;

  // Galois step: shift right, fold the polynomial in when the bit shifted out was 1.
  // Upper container bits must be zero on entry; they stay zero as long as poly fits the width.
  function automatic logic [63:0] lfsr_step(input logic [63:0] state, input logic [63:0] poly);
    logic [63:0] shifted;
    shifted = state >> 1;
    return state[0] ? (shifted ^ poly) : shifted;
  endfunction

  // MISR step for a width-bit register: shift left, fold poly on the outgoing msb, xor data in.
  function automatic logic [63:0] misr_step(input logic [63:0]  state,
                                            input logic [63:0]  poly,
                                            input int unsigned  width,
                                            input logic         data);
    logic [63:0] msb_vec;
    logic [63:0] mask;
    logic [63:0] next;
    msb_vec = state >> (width - 1);
    mask    = (64'd1 << width) - 64'd1;
    next    = (state << 1) ^ (msb_vec[0] ? poly : 64'd0) ^ {63'd0, data};
    return next & mask;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting one response bit per enabled cycle.
//   clk_i   : rising-edge clock
//   rst_ni  : synchronous active-low reset, clears the signature
//   clr_i   : synchronous clear (wins over en_i)
//   en_i    : compact data_i this cycle
//   data_i  : response bit
//   sig_o   : current signature
module bist_misr
  import subckt_bist_pkg::*;
#(
  parameter int unsigned        Width = 16,
  parameter logic [Width-1:0]   Poly  = DefMisrPoly
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             data_i,
  output logic [Width-1:0] sig_o
);

  logic [Width-1:0] sig_q;
  logic [Width-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = Width'(misr_step(64'(sig_q), 64'(Poly), Width, data_i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/subckt_pattern_driver.sv
// Built-in stimulus/response engine for one trojan-detection subcircuit.
// Drives LFSR patterns onto the subcircuit inputs, compacts the delayed single-bit response
// into a MISR and compares the final signature against a golden value.
//   I1294_clk   : rising-edge clock
//   I1301_rst   : synchronous active-low reset (aborts any run)
//   start       : one-cycle run request, honoured only in IDLE or DONE
//   golden      : expected signature, sampled as FLUSH ends
//   resp_in     : subcircuit output bit
//   pattern_out : registered stimulus to the subcircuit inputs
//   busy        : high while driving or flushing
//   done        : high in DONE until the next start or reset
//   pass        : signature == golden, latched on DONE entry
//   signature   : current MISR value
//
// Timing: a start sampled at edge t is registered first (reseed + MISR clear at t); DRIVE
// begins at edge t+1, so pattern k is on pattern_out after edge t+1+k and its response is
// compacted at edge t+1+k+LATENCY. DONE is entered at edge t+1+N_PATTERNS+LATENCY.
module subckt_pattern_driver
  import subckt_bist_pkg::*;
#(
  parameter int unsigned         N_IN       = 3,
  parameter int unsigned         LFSR_W     = 16,
  parameter logic [LFSR_W-1:0]   LFSR_POLY  = DefLfsrPoly,
  parameter logic [LFSR_W-1:0]   SEED       = DefLfsrSeed,
  parameter int unsigned         MISR_W     = 16,
  parameter logic [MISR_W-1:0]   MISR_POLY  = DefMisrPoly,
  parameter int unsigned         N_PATTERNS = 256,
  parameter int unsigned         LATENCY    = 6
) (
  input  logic              I1294_clk,
  input  logic              I1301_rst,
  input  logic              start,
  input  logic [MISR_W-1:0] golden,
  input  logic              resp_in,
  output logic [N_IN-1:0]   pattern_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  localparam int unsigned CntW   = $clog2(N_PATTERNS + 1);
  localparam int unsigned FlushW = $clog2(LATENCY + 1);
  // An all-zero seed would lock the LFSR.
  localparam logic [LFSR_W-1:0] SeedEff = (SEED == '0) ? LFSR_W'(1) : SEED;

  bist_state_e        state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [FlushW-1:0]  flush_q, flush_d;
  logic [N_IN-1:0]    pattern_out_q, pattern_out_d;
  logic               pass_q, pass_d;
  logic               start_q, start_d;
  logic [LATENCY-1:0] line_q, line_d;

  logic [LFSR_W-1:0]  lfsr_next;
  logic               start_ok;
  logic               misr_clr;
  logic               misr_en;

  assign lfsr_next = LFSR_W'(lfsr_step(64'(lfsr_q), 64'(LFSR_POLY)));

  // A start already pending in start_q blocks a second one during the hand-off cycle.
  assign start_ok = start && !start_q && ((state_q == StIdle) || (state_q == StDone));

  // Line output marks the cycle whose resp_in belongs to a driven pattern.
  assign misr_en = line_q[LATENCY-1];

  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    cnt_d         = cnt_q;
    flush_d       = flush_q;
    pattern_out_d = pattern_out_q;
    pass_d        = pass_q;
    start_d       = 1'b0;
    misr_clr      = 1'b0;

    if (start_ok) begin
      start_d  = 1'b1;
      lfsr_d   = SeedEff;
      misr_clr = 1'b1;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start_q) begin
          state_d       = StDrive;
          pattern_out_d = lfsr_q[N_IN-1:0];
          lfsr_d        = lfsr_next;
          cnt_d         = '0;
        end
      end
      StDrive: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N_PATTERNS - 1)) begin
          state_d       = StFlush;
          pattern_out_d = '0;
          flush_d       = '0;
        end else begin
          pattern_out_d = lfsr_q[N_IN-1:0];
          lfsr_d        = lfsr_next;
        end
      end
      StFlush: begin
        pattern_out_d = '0;
        if (flush_q == FlushW'(LATENCY - 1)) begin
          state_d = StDone;
          pass_d  = (signature == golden);
        end else begin
          flush_d = flush_q + FlushW'(1);
        end
      end
      default: begin
        state_d       = StIdle;
        pattern_out_d = '0;
      end
    endcase

    // Loaded on every edge that leaves the FSM in DRIVE, i.e. once per driven pattern.
    line_d = (line_q << 1) | LATENCY'(state_d == StDrive);
  end

  always_ff @(posedge I1294_clk) begin
    if (!I1301_rst) begin
      state_q       <= StIdle;
      lfsr_q        <= SeedEff;
      cnt_q         <= '0;
      flush_q       <= '0;
      pattern_out_q <= '0;
      pass_q        <= 1'b0;
      start_q       <= 1'b0;
      line_q        <= '0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      cnt_q         <= cnt_d;
      flush_q       <= flush_d;
      pattern_out_q <= pattern_out_d;
      pass_q        <= pass_d;
      start_q       <= start_d;
      line_q        <= line_d;
    end
  end

  bist_misr #(
    .Width (MISR_W),
    .Poly  (MISR_POLY)
  ) u_misr (
    .clk_i  (I1294_clk),
    .rst_ni (I1301_rst),
    .clr_i  (misr_clr),
    .en_i   (misr_en),
    .data_i (resp_in),
    .sig_o  (signature)
  );

  assign pattern_out = pattern_out_q;
  assign busy        = (state_q == StDrive) || (state_q == StFlush);
  assign done        = (state_q == StDone);
  assign pass        = pass_q;

endmodule

// File: tb/tb_subckt_pattern_driver.sv
// Directed bench: dut_a uses the default configuration with a small XOR-pipeline stand-in for
// the subcircuit; dut_b uses N_PATTERNS=2 with resp_in tied high for the alignment vectors.
module tb_subckt_pattern_driver;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        start_a, start_b;
  logic [15:0] golden_a, golden_b;
  logic        resp_a, resp_b;
  logic [2:0]  pat_a, pat_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [15:0] sig_a, sig_b;

  logic [4:0]  pipe;
  logic [15:0] exp_sig;
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  subckt_pattern_driver dut_a (
    .I1294_clk   (clk),
    .I1301_rst   (rst_a),
    .start       (start_a),
    .golden      (golden_a),
    .resp_in     (resp_a),
    .pattern_out (pat_a),
    .busy        (busy_a),
    .done        (done_a),
    .pass        (pass_a),
    .signature   (sig_a)
  );

  subckt_pattern_driver #(
    .N_PATTERNS (2)
  ) dut_b (
    .I1294_clk   (clk),
    .I1301_rst   (rst_b),
    .start       (start_b),
    .golden      (golden_b),
    .resp_in     (resp_b),
    .pattern_out (pat_b),
    .busy        (busy_b),
    .done        (done_b),
    .pass        (pass_b),
    .signature   (sig_b)
  );

  // Stand-in subcircuit: parity of the pattern, delayed so it lands on the compaction edge.
  always @(posedge clk) pipe <= {pipe[3:0], ^pat_a};
  assign resp_a = pipe[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_model(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [15:0] model_sig(input int n);
    logic [15:0] lf;
    logic [15:0] m;
    lf = 16'hACE1;
    m  = 16'h0000;
    for (int k = 0; k < n; k++) begin
      m  = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {15'd0, ^lf[2:0]};
      lf = lfsr_model(lf);
    end
    return m;
  endfunction

  // One full run on dut_a; abort_at >= 0 resets the DUT at that DRIVE cycle instead.
  task automatic run_a(input bit mid_start, input int abort_at);
    logic [15:0] lf;
    lf = 16'hACE1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("start_gap_busy", 32'(busy_a), 32'd0);
    chk("start_clr_sig", 32'(sig_a), 32'd0);
    for (int k = 0; k < 256; k++) begin
      start_a = mid_start && (k == 100);
      tick();
      start_a = 1'b0;
      if (k == abort_at) begin
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_sig", 32'(sig_a), 32'd0);
        chk("abort_pat", 32'(pat_a), 32'd0);
        chk("abort_done", 32'(done_a), 32'd0);
        tick();
        chk("abort_idle_busy", 32'(busy_a), 32'd0);
        return;
      end
      chk("drive_pat", 32'(pat_a), 32'(lf[2:0]));
      chk("drive_busy", 32'(busy_a), 32'd1);
      lf = lfsr_model(lf);
    end
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("flush_busy", 32'(busy_a), 32'd1);
      chk("flush_pat", 32'(pat_a), 32'd0);
      chk("flush_done", 32'(done_a), 32'd0);
    end
    tick();
    chk("done_flag", 32'(done_a), 32'd1);
    chk("done_busy", 32'(busy_a), 32'd0);
    chk("done_sig", 32'(sig_a), 32'(exp_sig));
    chk("done_pass", 32'(pass_a), 32'd1);
  endtask

  // One run on dut_b with resp_in high: signature 0 -> 1 -> 3 at edges t+7, t+8.
  task automatic run_b(input logic [15:0] gold, input logic exp_pass);
    golden_b = gold;
    start_b  = 1'b1;
    tick();
    start_b  = 1'b0;
    chk("b_start_sig", 32'(sig_b), 32'd0);
    repeat (6) tick();
    chk("b_sig_t6", 32'(sig_b), 32'h0000);
    tick();
    chk("b_sig_t7", 32'(sig_b), 32'h0001);
    tick();
    chk("b_sig_t8", 32'(sig_b), 32'h0003);
    chk("b_busy_t8", 32'(busy_b), 32'd1);
    tick();
    chk("b_done", 32'(done_b), 32'd1);
    chk("b_busy_done", 32'(busy_b), 32'd0);
    chk("b_pass", 32'(pass_b), 32'(exp_pass));
    tick();
    chk("b_sig_hold", 32'(sig_b), 32'h0003);
  endtask

  initial begin
    exp_sig  = model_sig(256);
    rst_a    = 1'b0;
    rst_b    = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    golden_a = exp_sig;
    golden_b = 16'h0003;
    resp_b   = 1'b1;
    repeat (3) tick();
    rst_a = 1'b1;
    rst_b = 1'b1;
    chk("rst_pat", 32'(pat_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_sig", 32'(sig_a), 32'd0);
    repeat (5) tick();
    chk("idle_busy", 32'(busy_a), 32'd0);
    chk("idle_done", 32'(done_a), 32'd0);
    chk("idle_pat", 32'(pat_a), 32'd0);

    // Full run from IDLE.
    run_a(1'b0, -1);
    // Restart from DONE with a start pulse ignored mid-DRIVE.
    run_a(1'b1, -1);
    // Reset at DRIVE cycle 50, then a clean run reproduces the signature.
    run_a(1'b0, 50);
    run_a(1'b0, -1);

    // Alignment with matching golden, then restart from DONE with a mismatching golden.
    run_b(16'h0003, 1'b1);
    run_b(16'h0002, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
